// File: rtl/alu_cmd_dispatch.sv
// Command FIFO and issue sequencer for the fixed-point ALU; keeps 8-beat transpose loads grouped.
// Optional blocked-cycle counter on o_stall_cnt when ALU_DISP_STALL_CNT_EN is defined.
module alu_cmd_dispatch #(
  parameter int unsigned       INST_W   = 4,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [INST_W-1:0] TRANS_OP = INST_W'(4'b1001)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [INST_W-1:0]        i_cmd_inst,
  input  logic [DATA_W-1:0]        i_cmd_a,
  input  logic [DATA_W-1:0]        i_cmd_b,
  output logic                     o_alu_valid,
  input  logic                     i_alu_busy,
  output logic [INST_W-1:0]        o_alu_inst,
  output logic [DATA_W-1:0]        o_alu_data_a,
  output logic [DATA_W-1:0]        o_alu_data_b,
  output logic [$clog2(DEPTH):0]   o_fifo_cnt,
  output logic [15:0]              o_stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = INST_W + 2 * DATA_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] LAST_BEAT   = 3'd7;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic             push, pop, empty, head_trans;
  logic [ENT_W-1:0] head;

  assign o_cmd_ready = (cnt_q < CNT_W'(DEPTH));
  assign o_fifo_cnt  = cnt_q;
  assign push        = i_cmd_valid & o_cmd_ready;
  assign empty       = (cnt_q == '0);
  assign head        = mem[rd_ptr_q];
  assign head_trans  = !empty && (head[ENT_W-1 -: INST_W] == TRANS_OP);

  // Command storage; contents need no reset since occupancy is tracked by cnt_q.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= {i_cmd_inst, i_cmd_a, i_cmd_b};
  end

  // Next-state logic; a pop always coincides with issuing the head to the ALU.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !i_alu_busy) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (o_alu_inst != TRANS_OP || beat_q == LAST_BEAT) begin
          beat_d  = 3'd0;
          state_d = S_WAIT_BUSY;
        end else begin
          beat_d = beat_q + 3'd1;
          if (head_trans && !i_alu_busy) pop = 1'b1;
          else state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Mid-group: only further transpose beats may go out until the group closes.
        if (head_trans && !i_alu_busy) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_WAIT_BUSY: begin
        if (i_alu_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!i_alu_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers, occupancy and registered ALU-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= 3'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      o_alu_valid  <= 1'b0;
      o_alu_inst   <= '0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      o_alu_valid <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        {o_alu_inst, o_alu_data_a, o_alu_data_b} <= head;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef ALU_DISP_STALL_CNT_EN
  // Counts cycles where work is queued but nothing leaves the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_stall_cnt <= 16'd0;
    else if (!empty && !pop && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
  end
`else
  assign o_stall_cnt = 16'd0;
`endif

endmodule
